psum_accum_ctrl: RTL and testbench

- Controller downstream of the output FIFO and in front of the 128-bit partial-sum SRAM in the core.
- Accumulate op: pops N rows of col x psum_bw results from the OFIFO and read-modify-writes them into psum SRAM rows base..base+N-1 with per-lane saturating signed add. On the first tile it writes the OFIFO data directly instead.
- ReLU op: sweeps the same rows and clamps negative lanes to zero in place.
- Replaces hand-sequenced CEN_pmem/WEN_pmem/A_pmem instruction bits with a start/done handshake.

---
 rtl/psum_accum_ctrl_pkg.sv | 25 ++
 rtl/psum_lane_alu.sv | 25 ++
 rtl/psum_accum_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_psum_accum_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_ctrl_pkg.sv
// rtl/psum_accum_ctrl_pkg.sv - shared types and constants for the psum accumulate/ReLU controller
package psum_accum_ctrl_pkg;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int ADDR_W  = 11;
    localparam int ROW_W   = COL * PSUM_BW;

    localparam logic OP_ACC  = 1'b0;
    localparam logic OP_RELU = 1'b1;

    localparam logic [PSUM_BW-1:0] LANE_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic [PSUM_BW-1:0] LANE_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC_WAIT,
        ST_ACC_RD,
        ST_ACC_WR,
        ST_RLU_RD,
        ST_RLU_WR,
        ST_FIN
    } state_t;

endpackage

// File: rtl/psum_lane_alu.sv
// rtl/psum_lane_alu.sv - one psum lane: saturating signed add or ReLU clamp
module psum_lane_alu
    import psum_accum_ctrl_pkg::*;
(
    input  logic               i_op,
    input  logic [PSUM_BW-1:0] i_mem,
    input  logic [PSUM_BW-1:0] i_ofifo,
    output logic [PSUM_BW-1:0] o_lane
);

    logic [PSUM_BW:0] w_sum;

    assign w_sum = {i_mem[PSUM_BW-1], i_mem} + {i_ofifo[PSUM_BW-1], i_ofifo};

    // Overflow shows up as the two top bits of the widened sum disagreeing.
    always_comb begin
        o_lane = w_sum[PSUM_BW-1:0];
        if (i_op == OP_RELU) begin
            o_lane = i_mem[PSUM_BW-1] ? '0 : i_mem;
        end else if (w_sum[PSUM_BW] != w_sum[PSUM_BW-1]) begin
            o_lane = w_sum[PSUM_BW] ? LANE_MIN : LANE_MAX;
        end
    end

endmodule

// File: rtl/psum_accum_ctrl.sv
// rtl/psum_accum_ctrl.sv - sequences OFIFO pops and psum SRAM read-modify-writes
module psum_accum_ctrl
    import psum_accum_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic              first,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_rows,
    input  logic              ofifo_valid,
    input  logic [ROW_W-1:0]  ofifo_out,
    output logic              ofifo_rd,
    output logic              CEN_pmem,
    output logic              WEN_pmem,
    output logic [ADDR_W-1:0] A_pmem,
    output logic [ROW_W-1:0]  D_pmem,
    input  logic [ROW_W-1:0]  Q_pmem,
    output logic              busy,
    output logic              done
);

    state_t r_state;
    state_t w_next;

    logic              r_op;
    logic              r_first;
    logic              r_rd_wait;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_num_rows;
    logic [ROW_W-1:0]  r_data;

    logic              r_ofifo_rd;
    logic              r_cen;
    logic              r_wen;
    logic [ADDR_W-1:0] r_a;
    logic [ROW_W-1:0]  r_d;
    logic              r_busy;
    logic              r_done;

    logic              w_ofifo_rd;
    logic              w_cen;
    logic              w_wen;
    logic [ADDR_W-1:0] w_a;
    logic [ROW_W-1:0]  w_d;
    logic              w_load;
    logic              w_pop;
    logic              w_adv;
    logic              w_rd_wait;
    logic              w_last;
    logic [ROW_W-1:0]  w_alu_row;

    for (genvar g = 0; g < COL; g++) begin : g_lane
        psum_lane_alu u_alu (
            .i_op    (r_op),
            .i_mem   (Q_pmem[g*PSUM_BW +: PSUM_BW]),
            .i_ofifo (r_data[g*PSUM_BW +: PSUM_BW]),
            .o_lane  (w_alu_row[g*PSUM_BW +: PSUM_BW])
        );
    end

    assign w_last = (r_count + ADDR_W'(1)) == r_num_rows;

    // Outputs are registered from the decision made in the current state, so a
    // read issued on leaving a state returns Q two states later (ACC_WR / RLU_WR).
    always_comb begin
        w_next     = r_state;
        w_ofifo_rd = 1'b0;
        w_cen      = 1'b1;
        w_wen      = 1'b1;
        w_a        = r_a;
        w_d        = r_d;
        w_load     = 1'b0;
        w_pop      = 1'b0;
        w_adv      = 1'b0;
        w_rd_wait  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    if (num_rows == '0)     w_next = ST_FIN;
                    else if (op == OP_RELU) w_next = ST_RLU_RD;
                    else                    w_next = ST_ACC_WAIT;
                end
            end
            ST_ACC_WAIT: begin
                if (ofifo_valid) begin
                    w_pop      = 1'b1;
                    w_ofifo_rd = 1'b1;
                    if (r_first) begin
                        w_next = ST_ACC_WR;
                    end else begin
                        w_cen  = 1'b0;
                        w_a    = r_cur;
                        w_next = ST_ACC_RD;
                    end
                end
            end
            ST_ACC_RD: w_next = ST_ACC_WR;
            ST_ACC_WR: begin
                w_cen  = 1'b0;
                w_wen  = 1'b0;
                w_a    = r_cur;
                w_d    = r_first ? r_data : w_alu_row;
                w_adv  = 1'b1;
                w_next = w_last ? ST_FIN : ST_ACC_WAIT;
            end
            ST_RLU_RD: begin
                // First cycle issues the read, second waits for it to land.
                if (!r_rd_wait) begin
                    w_cen     = 1'b0;
                    w_a       = r_cur;
                    w_rd_wait = 1'b1;
                end else begin
                    w_next = ST_RLU_WR;
                end
            end
            ST_RLU_WR: begin
                w_cen  = 1'b0;
                w_wen  = 1'b0;
                w_a    = r_cur;
                w_d    = w_alu_row;
                w_adv  = 1'b1;
                w_next = w_last ? ST_FIN : ST_RLU_RD;
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= 1'b0;
            r_first    <= 1'b0;
            r_rd_wait  <= 1'b0;
            r_cur      <= '0;
            r_count    <= '0;
            r_num_rows <= '0;
            r_data     <= '0;
            r_ofifo_rd <= 1'b0;
            r_cen      <= 1'b1;
            r_wen      <= 1'b1;
            r_a        <= '0;
            r_d        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ofifo_rd <= w_ofifo_rd;
            r_cen      <= w_cen;
            r_wen      <= w_wen;
            r_a        <= w_a;
            r_d        <= w_d;
            r_busy     <= (w_next != ST_IDLE);
            r_done     <= (w_next == ST_FIN);
            r_rd_wait  <= w_rd_wait;
            if (w_load) begin
                r_op       <= op;
                r_first    <= first;
                r_cur      <= base_addr;
                r_num_rows <= num_rows;
                r_count    <= '0;
            end
            if (w_pop) r_data <= ofifo_out;
            if (w_adv) begin
                r_cur   <= r_cur + ADDR_W'(1);
                r_count <= r_count + ADDR_W'(1);
            end
        end
    end

    assign ofifo_rd = r_ofifo_rd;
    assign CEN_pmem = r_cen;
    assign WEN_pmem = r_wen;
    assign A_pmem   = r_a;
    assign D_pmem   = r_d;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// tb/tb_psum_accum_ctrl.sv - self-checking bench for psum_accum_ctrl
module tb_psum_accum_ctrl;
    import psum_accum_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic         first = 1'b0;
    logic [10:0]  base_addr = '0;
    logic [10:0]  num_rows = '0;
    logic         ofifo_valid;
    logic [127:0] ofifo_out;
    logic         ofifo_rd;
    logic         CEN_pmem;
    logic         WEN_pmem;
    logic [10:0]  A_pmem;
    logic [127:0] D_pmem;
    logic [127:0] Q_pmem;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    psum_accum_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .first(first),
        .base_addr(base_addr), .num_rows(num_rows),
        .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
        .CEN_pmem(CEN_pmem), .WEN_pmem(WEN_pmem), .A_pmem(A_pmem),
        .D_pmem(D_pmem), .Q_pmem(Q_pmem), .busy(busy), .done(done)
    );

    // SRAM model with a bench-side preload port
    logic [127:0] mem [0:2047];
    logic [127:0] q_reg = '0;
    logic         pl_en = 1'b0;
    logic [10:0]  pl_addr = '0;
    logic [127:0] pl_data = '0;
    assign Q_pmem = q_reg;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (!CEN_pmem) begin
            if (!WEN_pmem) mem[A_pmem] <= D_pmem;
            else           q_reg <= mem[A_pmem];
        end
    end

    // OFIFO model; stalls only start right after a pop so valid never drops under ofifo_rd
    logic [127:0] fifo_mem [0:255];
    logic [7:0]   fifo_wr = '0;
    logic [7:0]   fifo_rd = '0;
    int           stall = 0;
    bit           stall_en = 1'b0;
    assign ofifo_valid = (fifo_rd != fifo_wr) && (stall == 0);
    assign ofifo_out   = fifo_mem[fifo_rd];
    always @(posedge clk) begin
        if (ofifo_rd) begin
            fifo_rd <= fifo_rd + 8'd1;
            stall   <= stall_en ? int'($urandom_range(0, 3)) : 0;
        end else if (stall != 0) begin
            stall <= stall - 1;
        end
    end

    int rd_cnt = 0, done_cnt = 0, acc_cnt = 0, viol = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (ofifo_rd)              rd_cnt   <= rd_cnt + 1;
            if (done)                  done_cnt <= done_cnt + 1;
            if (!CEN_pmem)             acc_cnt  <= acc_cnt + 1;
            if (ofifo_rd && !ofifo_valid) viol  <= viol + 1;
        end
    end

    int total = 0;
    int bad = 0;
    logic [127:0] exp_mem [0:2047];
    logic [127:0] model_q [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] splat(input logic [15:0] v);
        return {8{v}};
    endfunction

    function automatic logic [127:0] ref_add(input logic [127:0] s, input logic [127:0] f);
        logic [127:0] r;
        int a, b, x;
        for (int i = 0; i < 8; i++) begin
            a = int'($signed(s[i*16 +: 16]));
            b = int'($signed(f[i*16 +: 16]));
            x = a + b;
            if (x > 32767)  x = 32767;
            if (x < -32768) x = -32768;
            r[i*16 +: 16] = 16'(x);
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_relu(input logic [127:0] s);
        logic [127:0] r;
        int x;
        for (int i = 0; i < 8; i++) begin
            x = int'($signed(s[i*16 +: 16]));
            r[i*16 +: 16] = (x < 0) ? 16'h0000 : 16'(x);
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd_row();
        logic [127:0] r;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0:       r[i*16 +: 16] = 16'h7F00 | 16'($urandom_range(0, 255));
                1:       r[i*16 +: 16] = 16'h8000 | 16'($urandom_range(0, 255));
                default: r[i*16 +: 16] = 16'($urandom());
            endcase
        end
        return r;
    endfunction

    task automatic preload(input logic [10:0] a, input logic [127:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic push(input logic [127:0] d);
        fifo_mem[fifo_wr] = d;
        fifo_wr = fifo_wr + 8'd1;
        model_q.push_back(d);
    endtask

    task automatic model_acc(input logic f, input logic [10:0] b, input int n);
        logic [10:0]  a;
        logic [127:0] d;
        for (int i = 0; i < n; i++) begin
            a = b + 11'(i);
            d = model_q.pop_front();
            exp_mem[a] = f ? d : ref_add(exp_mem[a], d);
        end
    endtask

    task automatic model_relu(input logic [10:0] b, input int n);
        logic [10:0] a;
        for (int i = 0; i < n; i++) begin
            a = b + 11'(i);
            exp_mem[a] = ref_relu(exp_mem[a]);
        end
    endtask

    task automatic check_rows(input string tag, input logic [10:0] b, input int n);
        logic [10:0] a;
        for (int i = 0; i < n; i++) begin
            a = b + 11'(i);
            chk($sformatf("%s_row%0d", tag, a), mem[a], exp_mem[a]);
        end
    endtask

    task automatic run_cmd(input logic op_i, input logic first_i, input logic [10:0] base_i,
                           input logic [10:0] n_i, input bit poke, output int dcyc);
        @(negedge clk);
        start = 1'b1; op = op_i; first = first_i; base_addr = base_i; num_rows = n_i;
        @(negedge clk);
        start = 1'b0;
        dcyc = -1;
        chk_i("busy_after_start", int'(busy), 1);
        for (int c = 1; c <= 5000; c++) begin
            if (done) begin
                dcyc = c;
                break;
            end
            if (poke && c == 2) begin
                start = 1'b1; op = ~op_i; first = ~first_i;
                base_addr = base_i + 11'd7; num_rows = 11'd0;
            end else if (poke && c == 3) begin
                start = 1'b0; op = op_i; first = first_i;
                base_addr = base_i; num_rows = n_i;
            end
            @(negedge clk);
        end
        chk_i("done_seen", int'(dcyc >= 0), 1);
        @(negedge clk);
        chk_i("busy_after_done", int'(busy), 0);
        chk_i("done_single_cycle", int'(done), 0);
    endtask

    initial begin
        int dcyc, rd0, acc0, done0, wr;
        bit found;
        logic [127:0] row;
        logic [10:0] b;
        int n;
        logic o, f;

        // asynchronous reset before any clock edge
        #1 reset = 1'b1;
        #1;
        chk_i("rst_ofifo_rd", int'(ofifo_rd), 0);
        chk_i("rst_cen", int'(CEN_pmem), 1);
        chk_i("rst_wen", int'(WEN_pmem), 1);
        chk_i("rst_addr", int'(A_pmem), 0);
        chk("rst_d", D_pmem, '0);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // overwrite on first tile, two rows at base 5
        push(splat(16'd3));
        push(splat(16'd7));
        rd0 = rd_cnt;
        run_cmd(OP_ACC, 1'b1, 11'd5, 11'd2, 1'b0, dcyc);
        model_acc(1'b1, 11'd5, 2);
        chk_i("first_done_cycle", dcyc, 5);
        chk_i("first_rd_pulses", rd_cnt - rd0, 2);
        chk("first_row5", mem[5], splat(16'h0003));
        chk("first_row6", mem[6], splat(16'h0007));

        // accumulate with saturation at both ends
        preload(11'd5, splat(16'd100));
        push(splat(16'hFFE2));
        run_cmd(OP_ACC, 1'b0, 11'd5, 11'd1, 1'b0, dcyc);
        model_acc(1'b0, 11'd5, 1);
        chk_i("acc_done_cycle", dcyc, 4);
        chk("acc_100_m30", mem[5], splat(16'h0046));
        preload(11'd5, splat(16'h7D00));
        push(splat(16'h03E8));
        run_cmd(OP_ACC, 1'b0, 11'd5, 11'd1, 1'b0, dcyc);
        model_acc(1'b0, 11'd5, 1);
        chk("acc_sat_pos", mem[5], splat(16'h7FFF));
        preload(11'd5, splat(16'h8300));
        push(splat(16'hFC18));
        run_cmd(OP_ACC, 1'b0, 11'd5, 11'd1, 1'b0, dcyc);
        model_acc(1'b0, 11'd5, 1);
        chk("acc_sat_neg", mem[5], splat(16'h8000));
        check_rows("acc_model", 11'd5, 2);

        // OFIFO runs dry for 10 cycles mid-command
        for (int i = 0; i < 3; i++) preload(11'(20 + i), rnd_row());
        push(rnd_row());
        rd0 = rd_cnt;
        @(negedge clk);
        start = 1'b1; op = OP_ACC; first = 1'b0; base_addr = 11'd20; num_rows = 11'd3;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (!CEN_pmem && !WEN_pmem) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk_i("stall_first_write", int'(found), 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk_i($sformatf("stall_rd_c%0d", c), int'(ofifo_rd), 0);
            chk_i($sformatf("stall_cen_c%0d", c), int'(CEN_pmem), 1);
            chk_i($sformatf("stall_busy_c%0d", c), int'(busy), 1);
        end
        push(rnd_row());
        push(rnd_row());
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        chk_i("stall_done", int'(found), 1);
        model_acc(1'b0, 11'd20, 3);
        @(negedge clk);
        chk_i("stall_rd_pulses", rd_cnt - rd0, 3);
        check_rows("stall", 11'd20, 3);

        // ReLU sweep across the address wrap
        preload(11'd1, splat(16'hFFF0));
        for (int i = 0; i < 3; i++) begin
            row = rnd_row();
            row[15:0] = 16'hFFFB;
            row[31:16] = 16'h0000;
            row[47:32] = 16'h0009;
            preload(11'd2046 + 11'(i), row);
        end
        rd0 = rd_cnt;
        run_cmd(OP_RELU, 1'b0, 11'd2046, 11'd3, 1'b0, dcyc);
        model_relu(11'd2046, 3);
        chk_i("relu_done_cycle", dcyc, 10);
        chk_i("relu_no_pop", rd_cnt - rd0, 0);
        check_rows("relu", 11'd2046, 3);
        chk("relu_lanes_addr0", mem[0] & 128'hFFFF_FFFF_FFFF, 128'h0009_0000_0000);
        chk("relu_untouched_addr1", mem[1], splat(16'hFFF0));

        // empty command and start while busy
        @(negedge clk);
        rd0 = rd_cnt; acc0 = acc_cnt;
        run_cmd(OP_ACC, 1'b0, 11'd40, 11'd0, 1'b0, dcyc);
        chk_i("zero_done_cycle", dcyc, 1);
        chk_i("zero_no_pop", rd_cnt - rd0, 0);
        chk_i("zero_no_sram", acc_cnt - acc0, 0);
        push(rnd_row());
        push(rnd_row());
        done0 = done_cnt;
        run_cmd(OP_ACC, 1'b1, 11'd300, 11'd2, 1'b1, dcyc);
        model_acc(1'b1, 11'd300, 2);
        chk_i("poke_done_cycle", dcyc, 5);
        chk_i("poke_single_done", done_cnt - done0, 1);
        check_rows("poke", 11'd300, 2);

        // randomized commands against the reference model
        stall_en = 1'b1;
        for (int t = 0; t < 12; t++) begin
            o = 1'($urandom_range(0, 1));
            f = 1'($urandom_range(0, 1));
            b = (t % 3 == 0) ? 11'(2044 + $urandom_range(0, 3)) : 11'($urandom_range(0, 2047));
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) preload(b + 11'(i), rnd_row());
            if (o == OP_ACC) for (int i = 0; i < n; i++) push(rnd_row());
            rd0 = rd_cnt;
            run_cmd(o, f, b, 11'(n), 1'b0, dcyc);
            if (o == OP_ACC) model_acc(f, b, n);
            else             model_relu(b, n);
            chk_i($sformatf("rand%0d_pops", t), rd_cnt - rd0, (o == OP_ACC) ? n : 0);
            if (o == OP_RELU) chk_i($sformatf("rand%0d_relu_cycles", t), dcyc, 3 * n + 1);
            check_rows($sformatf("rand%0d", t), b, n);
        end
        stall_en = 1'b0;
        repeat (5) @(negedge clk);

        // asynchronous reset while the third row is in ACC_WR
        for (int i = 0; i < 4; i++) preload(11'(100 + i), rnd_row());
        for (int i = 0; i < 4; i++) push(rnd_row());
        done0 = done_cnt;
        @(negedge clk);
        start = 1'b1; op = OP_ACC; first = 1'b0; base_addr = 11'd100; num_rows = 11'd4;
        @(negedge clk);
        start = 1'b0;
        wr = 0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!CEN_pmem && !WEN_pmem) wr++;
            if (wr == 2 && !CEN_pmem && WEN_pmem) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk_i("midrst_reached", int'(found), 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk_i("midrst_ofifo_rd", int'(ofifo_rd), 0);
        chk_i("midrst_cen", int'(CEN_pmem), 1);
        chk_i("midrst_wen", int'(WEN_pmem), 1);
        chk_i("midrst_addr", int'(A_pmem), 0);
        chk("midrst_d", D_pmem, '0);
        chk_i("midrst_busy", int'(busy), 0);
        chk_i("midrst_done", int'(done), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk_i("midrst_no_done", done_cnt - done0, 0);
        chk_i("midrst_idle", int'(busy), 0);
        model_acc(1'b0, 11'd100, 2);
        check_rows("midrst", 11'd100, 4);

        chk_i("ofifo_rd_without_valid", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
